// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the memory ISSUE phase: counts enabled cycles and flags
// expiry in the TIMEOUT_CYC-th consecutive enabled cycle.
module mem_arb_wdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  assign expire_c = en && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count while enabled; any cycle outside ISSUE or a completion restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between the L1 I-cache and D-cache
// controllers. Define ARB_RR_EN for round-robin between simultaneous
// requesters; otherwise the D-side has fixed priority over the I-side.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  state_t state;
  state_t state_nxt;

  logic owner;
  logic op;
  logic i_act_c;
  logic d_act_c;
  logic pick_d_c;
  logic wr_c;
  logic grant_c;
  logic done_c;
  logic expire_c;

  assign i_act_c = i_req;
  assign d_act_c = d_rd | d_wr;
  assign wr_c    = pick_d_c & d_wr;

`ifdef ARB_RR_EN
  logic last_d;

  // On contention grant whichever side was not granted last.
  assign pick_d_c = d_act_c & (~i_act_c | ~last_d);

  // Remember the side of every grant; reset means "I granted last".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (grant_c) begin
      last_d <= pick_d_c;
    end
  end
`else
  assign pick_d_c = d_act_c;
`endif

  // Watchdog only runs while a command is outstanding.
  mem_arb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state == ISSUE),
    .clr     (done_c),
    .expire_c(expire_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; mem_ack beats a same-cycle watchdog expiry.
  always_comb begin
    state_nxt = state;
    grant_c   = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_act_c || d_act_c) begin
          grant_c   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack || expire_c) begin
          done_c    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered command, response and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_I;
      op        <= OP_RD;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      busy  <= (state_nxt != IDLE);
      if (grant_c) begin
        owner     <= pick_d_c ? OWN_D : OWN_I;
        op        <= wr_c ? OP_WR : OP_RD;
        mem_addr  <= pick_d_c ? d_addr : i_addr;
        mem_wdata <= d_wdata;
        mem_rd    <= ~wr_c;
        mem_wr    <= wr_c;
      end
      if (done_c) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
        if (owner == OWN_D) begin
          d_ack <= 1'b1;
        end else begin
          i_ack <= 1'b1;
        end
        if (!mem_ack) begin
          err <= 1'b1;
          if (owner == OWN_D) begin
            d_rdata <= '0;
          end else begin
            i_rdata <= '0;
          end
        end else if (op == OP_RD) begin
          if (owner == OWN_D) begin
            d_rdata <= mem_rdata;
          end else begin
            i_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level
// model of grant choice, latency, returned data and error status.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_rd = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  bit            exp_err = 1'b0;
  bit            last_d = 1'b0;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_rd     (d_rd),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Which side wins when both sides are sampled in IDLE.
  function automatic bit model_pick_d(input bit i_on, input bit d_on);
`ifdef ARB_RR_EN
    if (i_on && d_on) return !last_d;
    return d_on;
`else
    return d_on;
`endif
  endfunction

  // Addresses of idle requesters wander; held registers must not follow them.
  task automatic churn();
    if (!i_req) i_addr = $urandom;
    if (!(d_rd || d_wr)) begin
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
  endtask

  // Called in an IDLE cycle with requests already driven; memory acks in the
  // k-th ISSUE cycle (never if k > TO). Returns in the following IDLE cycle.
  task automatic do_txn(input int k, input logic [DW-1:0] rv, input bit keep);
    bit            win_d;
    bit            is_wr;
    bit            acked;
    int            t_end;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    win_d   = model_pick_d(i_req, d_rd | d_wr);
    is_wr   = win_d && d_wr;
    e_addr  = win_d ? d_addr : i_addr;
    e_wdata = d_wdata;
    acked   = (k <= int'(TO));
    t_end   = acked ? k : int'(TO);
    last_d  = win_d;
    tick();
    for (int c = 1; c <= t_end; c++) begin
      check("issue_busy", busy, 1);
      check("issue_mem_rd", mem_rd, !is_wr);
      check("issue_mem_wr", mem_wr, is_wr);
      check("issue_mem_addr", mem_addr, e_addr);
      if (is_wr) check("issue_mem_wdata", mem_wdata, e_wdata);
      check("issue_i_ack", i_ack, 0);
      check("issue_d_ack", d_ack, 0);
      if (c == k) begin
        mem_ack   = 1'b1;
        mem_rdata = rv;
      end
      if (!keep && c == 1 && $urandom_range(0, 3) == 0) begin
        if (win_d) begin
          d_rd = 1'b0;
          d_wr = 1'b0;
        end else begin
          i_req = 1'b0;
        end
      end
      churn();
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    if (!acked) begin
      exp_err = 1'b1;
      if (win_d) exp_d_rdata = '0;
      else       exp_i_rdata = '0;
    end else if (!is_wr) begin
      if (win_d) exp_d_rdata = rv;
      else       exp_i_rdata = rv;
    end
    check("resp_i_ack", i_ack, !win_d);
    check("resp_d_ack", d_ack, win_d);
    check("resp_i_rdata", i_rdata, exp_i_rdata);
    check("resp_d_rdata", d_rdata, exp_d_rdata);
    check("resp_err", err, exp_err);
    check("resp_busy", busy, 1);
    check("resp_mem_rd", mem_rd, 0);
    check("resp_mem_wr", mem_wr, 0);
    if (!keep) begin
      if (win_d) begin
        d_rd = 1'b0;
        d_wr = 1'b0;
      end else begin
        i_req = 1'b0;
      end
    end
    mem_ack = 1'($urandom_range(0, 1));
    tick();
    check("rel_i_ack", i_ack, 0);
    check("rel_d_ack", d_ack, 0);
    check("rel_busy", busy, 1);
    check("rel_mem_rd", mem_rd, 0);
    mem_ack = 1'($urandom_range(0, 1));
    tick();
    mem_ack = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_i_ack", i_ack, 0);
    check("idle_d_ack", d_ack, 0);
    check("idle_i_rdata", i_rdata, exp_i_rdata);
    check("idle_d_rdata", d_rdata, exp_d_rdata);
    check("idle_err", err, exp_err);
  endtask

  initial begin
    #3;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    tick();
    rst = 1'b1;

    // I read alone, memory acks in the third ISSUE cycle.
    i_req  = 1'b1;
    i_addr = 32'h100;
    do_txn(3, 32'hDEADBEEF, 0);

    // D write alone, zero-wait memory.
    d_wr    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'h12345678;
    do_txn(1, 32'h0, 0);

    // Both sides held through three transactions.
    i_req  = 1'b1;
    i_addr = 32'h200;
    d_rd   = 1'b1;
    d_addr = 32'h300;
    for (int n = 0; n < 3; n++) do_txn(1 + n, $urandom, 1);
    i_req = 1'b0;
    d_rd  = 1'b0;

    // Memory never acks: timeout.
    d_rd   = 1'b1;
    d_addr = 32'h80;
    do_txn(1000, 32'h0, 0);

    // Simultaneous d_rd and d_wr issue a write; ack coincides with expiry.
    d_rd    = 1'b1;
    d_wr    = 1'b1;
    d_wdata = 32'hCAFEF00D;
    do_txn(int'(TO), 32'h0, 0);

    // Reset in ISSUE discards the transaction; held request is re-granted.
    i_req  = 1'b1;
    i_addr = 32'h500;
    tick();
    check("pre_rst_mem_rd", mem_rd, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_mem_rd", mem_rd, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_i_ack", i_ack, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_i_rdata", i_rdata, 0);
    exp_err     = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    last_d      = 1'b0;
    tick();
    check("in_rst_i_ack", i_ack, 0);
    rst = 1'b1;
    do_txn(2, $urandom, 0);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req  = 1'b1;
        i_addr = $urandom;
      end
      if (!(d_rd || d_wr) && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0:       begin d_rd = 1'b1; d_wr = 1'b0; end
          1:       begin d_rd = 1'b0; d_wr = 1'b1; end
          default: begin d_rd = 1'b1; d_wr = 1'b1; end
        endcase
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      if (i_req || d_rd || d_wr) begin
        do_txn($urandom_range(1, TO + 2), $urandom, 0);
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        tick();
        mem_ack = 1'b0;
        check("quiet_busy", busy, 0);
        check("quiet_mem_rd", mem_rd, 0);
        check("quiet_i_ack", i_ack, 0);
        check("quiet_d_ack", d_ack, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no completion, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port of the pipelined CPU between the L1 instruction-cache and L1 data-cache controllers. Each cache controller raises a level request on miss (I-side read fill) or on D-side read fill/write-through; the arbiter grants one requester, holds the memory command until the memory acknowledges, and returns read data plus a one-cycle acknowledge. A watchdog aborts transactions that the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- TIMEOUT_CYC, 255, max cycles in ISSUE before abort (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  I-cache read request, held until i_ack
- i_addr  in  ADDR_W  I-cache address
- i_rdata  out  DATA_W  read data, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse to I-cache
- d_rd  in  1  D-cache read request, held until d_ack
- d_wr  in  1  D-cache write request, held until d_ack
- d_addr  in  ADDR_W  D-cache address
- d_wdata  in  DATA_W  D-cache write data
- d_rdata  out  DATA_W  read data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse to D-cache
- mem_rd  out  1  memory read command, level
- mem_wr  out  1  memory write command, level
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- busy  out  1  state ≠ IDLE
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, ISSUE, RESP, RELEASE.
- IDLE: sample requests. I-side active = i_req; D-side active = d_rd|d_wr. If none → stay. Else pick winner (see arbitration), register addr, wdata, op, owner; → ISSUE.
- D-side op: d_wr=1 → write (d_wr wins if d_rd and d_wr both high); else read. I-side always read.
- ISSUE: mem_rd or mem_wr held high with mem_addr/mem_wdata stable. mem_ack=1 → latch mem_rdata (reads) into owner's rdata register; → RESP. Watchdog counts cycles in ISSUE; reaching TIMEOUT_CYC without mem_ack → rdata register cleared to 0, err set; → RESP.
- RESP: owner's ack=1 for exactly one cycle, rdata valid; mem_rd=mem_wr=0; → RELEASE.
- RELEASE: one dead cycle letting requester drop its request; no sampling; → IDLE.
- Arbitration default: fixed priority, D over I.
- Requester dropping request during ISSUE: transaction still completes, ack still pulsed.
- mem_ack outside ISSUE: ignored.
- Non-owner ack stays 0; non-owner rdata holds previous value.
- err: set on timeout, cleared only by reset.

## Timing
- Reset (rst=0) immediately: state IDLE, all acks/commands 0, mem_addr/mem_wdata/i_rdata/d_rdata 0, busy=0, err=0, watchdog 0, RR pointer = "I last granted". In-flight transaction discarded, no ack.
- Request seen edge 0 → mem command high from cycle 1. mem_ack in cycle k (k≥1) → ack high cycle k+1 → RELEASE k+2 → IDLE k+3 (earliest next grant sampled).
- Minimum turnaround: 4 cycles per transaction with zero-wait memory (mem_ack in first ISSUE cycle).
- Timeout: ack pulse in cycle TIMEOUT_CYC+1 after entering ISSUE.
- mem_ack and timeout in same cycle: mem_ack wins, err not set.
- Watchdog width $clog2(TIMEOUT_CYC+1); resets to 0 on leaving ISSUE.

## Configuration
- ARB_RR_EN defined: round-robin; on simultaneous I and D requests in IDLE, grant the side not granted last; pointer updates on every grant. Single requester always granted.
- Undefined: fixed D-over-I priority; pointer logic absent.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ISSUE, RESP, RELEASE), owner constants (OWN_I, OWN_D), op constants (OP_RD, OP_WR).
- One sub-module: mem_arb_wdog (watchdog counter: enable, clear, TIMEOUT_CYC parameter, expire output).

## Test plan
- I read alone, i_addr=0x100, mem_ack 2 cycles after mem_rd, mem_rdata=0xDEADBEEF → mem_rd cycles 1–3, i_ack cycle 4 with i_rdata=0xDEADBEEF, d_ack never.
- D write alone, d_addr=0x40, d_wdata=0x12345678, mem_ack in cycle 1 → mem_wr=1, mem_wdata=0x12345678 cycle 1, d_ack cycle 2, IDLE cycle 4.
- i_req and d_rd asserted together, held through 3 transactions → fixed: D, D, D; with ARB_RR_EN: D, I, D.
- Memory never acks, TIMEOUT_CYC=4 → owner ack with rdata=0, err=1 and stays 1 through later good transactions.
- rst low during ISSUE → mem_rd drops immediately, no ack, busy=0; after release, pending request re-granted.
- d_rd=d_wr=1 simultaneously → write issued (mem_wr=1, mem_rd=0).
